// File: rtl/stat_link_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stat_link_tx_if : peer-status link bundle (status, attack handshake, line)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface stat_link_tx_if;
  logic [2:0] stat_in;
  logic       atk_valid;
  logic [2:0] atk_lines;
  logic       atk_ready;
  logic       tx_line;
  logic       busy;
  logic       frame_sent;

  modport master (
    output stat_in, atk_valid, atk_lines,
    input  atk_ready, tx_line, busy, frame_sent
  );

  modport slave (
    input  stat_in, atk_valid, atk_lines,
    output atk_ready, tx_line, busy, frame_sent
  );
endinterface
`default_nettype wire

// File: rtl/stat_link_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stat_link_tx : framed serial sender of game status + attack count
// Revision: 1.0
// ---------------------------------------------------------------------------
module stat_link_tx #(
  parameter int CLKS_PER_BIT   = 1000,
  parameter int HEARTBEAT_BITS = 64
) (
  input logic        global_clk,
  input logic        rst,
  stat_link_tx_if.slave lnk
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int HBW = $clog2(HEARTBEAT_BITS + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [HBW-1:0] HB_MAX   = HBW'(HEARTBEAT_BITS);
  localparam logic [HBW-1:0] HB_PRE   = HBW'(HEARTBEAT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GUARD  = 3'd5
  } state_t;

  state_t         state, state_nx;
  logic           tx_q, tx_nx;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [5:0]     shreg;
  logic           par;
  logic [2:0]     atk_reg;
  logic           atk_full;
  logic [2:0]     last_stat;
  logic [HBW-1:0] hb;
  logic           force_send;

  logic       bit_end, atk_accept, hb_hit, trigger;
  logic       load, shift, idx_clr, idx_inc;
  logic [2:0] atk_snap;

  assign bit_end    = (cnt == CNT_LAST);
  assign atk_accept = lnk.atk_valid && !atk_full;
  // Fire on the cycle the final idle bit period completes so frames repeat on bit boundaries.
  assign hb_hit     = (hb == HB_MAX) || (bit_end && (hb == HB_PRE));
  assign trigger    = force_send || atk_full || (lnk.stat_in != last_stat) || hb_hit;
  // An attack accepted in the snapshot cycle bypasses the holding register.
  assign atk_snap   = atk_full ? atk_reg : (atk_accept ? lnk.atk_lines : 3'b000);

  always_ff @(posedge global_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_nx    = tx_q;
    load     = 1'b0;
    shift    = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    case (state)
      IDLE: if (trigger) begin
        state_nx = START;
        tx_nx    = 1'b0;
        load     = 1'b1;
      end
      START: if (bit_end) begin
        state_nx = DATA;
        tx_nx    = shreg[0];
        idx_clr  = 1'b1;
      end
      DATA: if (bit_end) begin
        shift = 1'b1;
        if (idx == 3'd5) begin
          state_nx = PARITY;
          tx_nx    = par;
        end else begin
          tx_nx   = shreg[1];
          idx_inc = 1'b1;
        end
      end
      PARITY: if (bit_end) begin
        state_nx = STOP;
        tx_nx    = 1'b1;
      end
      STOP: if (bit_end) begin
        state_nx = GUARD;
        idx_clr  = 1'b1;
      end
      GUARD: if (bit_end) begin
        if (idx == 3'd1) state_nx = IDLE;
        else             idx_inc  = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge global_clk or posedge rst) begin
    if (rst) begin
      tx_q       <= 1'b1;
      cnt        <= '0;
      idx        <= 3'd0;
      shreg      <= 6'd0;
      par        <= 1'b0;
      atk_reg    <= 3'd0;
      atk_full   <= 1'b0;
      last_stat  <= 3'd0;
      hb         <= '0;
      force_send <= 1'b1;
    end else begin
      tx_q <= tx_nx;
      cnt  <= (load || bit_end) ? '0 : cnt + 1'b1;

      if (idx_clr)      idx <= 3'd0;
      else if (idx_inc) idx <= idx + 3'd1;

      if (load) begin
        shreg      <= {atk_snap, lnk.stat_in};
        par        <= ^{atk_snap, lnk.stat_in};
        last_stat  <= lnk.stat_in;
        force_send <= 1'b0;
      end else if (shift) begin
        shreg <= {1'b0, shreg[5:1]};
      end

      if (load) begin
        atk_full <= 1'b0;
      end else if (atk_accept && (lnk.atk_lines != 3'b000)) begin
        atk_full <= 1'b1;
        atk_reg  <= lnk.atk_lines;
      end

      if (load)
        hb <= '0;
      else if ((state == IDLE) && bit_end && (hb != HB_MAX))
        hb <= hb + 1'b1;
    end
  end

  assign lnk.tx_line    = tx_q;
  assign lnk.busy       = (state != IDLE);
  assign lnk.frame_sent = (state == STOP) && bit_end;
  assign lnk.atk_ready  = !atk_full;

endmodule
`default_nettype wire
